// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage (with control_unit, sign_extend)
// Description : Pipelined RV32I decode stage. Owns the F/D pipeline register,
//               the architectural register file (write-first W-stage bypass),
//               load-use hazard detection, stall/flush control and a debug
//               read port. Decoded outputs come from the F/D register, so
//               they appear one cycle after fetch.
// Ports       : clk/rst                          clock, sync active-high reset
//               ins_f/pc_f/pc_plus_4_f/valid_f   fetch-stage inputs
//               stall_i/flush_d                  hold / kill the F/D slot
//               reg_write_w/rd_w/result_w        writeback port
//               result_src_e/rd_e                E-stage info for load-use
//               dbg_addr/dbg_data                bypass-free register peek
//               *_d, rd_1, rd_2, hazard_stall    decode results
// Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// control_unit: main decoder + ALU decoder.
// alu_control: 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR,
//              0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B
// result_src : 00 ALU, 01 memory, 10 PC+4, 11 PC+imm
// imm_src    : 000 I, 001 S, 010 B, 011 U, 100 J
// ----------------------------------------------------------------------------
module control_unit (
    input  logic [6:0] i_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic       o_mem_write,
    output logic       o_branch,
    output logic       o_jump,
    output logic [3:0] o_alu_control,
    output logic       o_alu_src,
    output logic [2:0] o_imm_src
);
    localparam logic [6:0] C_OP_R     = 7'b0110011;
    localparam logic [6:0] C_OP_I     = 7'b0010011;
    localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] C_OP_STORE = 7'b0100011;
    localparam logic [6:0] C_OP_BR    = 7'b1100011;
    localparam logic [6:0] C_OP_JAL   = 7'b1101111;
    localparam logic [6:0] C_OP_JALR  = 7'b1100111;
    localparam logic [6:0] C_OP_LUI   = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC = 7'b0010111;

    logic w_arith;  // ALU op taken from funct3/funct7

    always_comb begin
        o_reg_write  = 1'b0;
        o_result_src = 2'b00;
        o_mem_write  = 1'b0;
        o_branch     = 1'b0;
        o_jump       = 1'b0;
        o_alu_src    = 1'b0;
        o_imm_src    = 3'b000;
        w_arith      = 1'b0;
        case (i_op)
            C_OP_R:     begin o_reg_write = 1'b1; w_arith = 1'b1; end
            C_OP_I:     begin o_reg_write = 1'b1; o_alu_src = 1'b1; w_arith = 1'b1; end
            C_OP_LOAD:  begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_result_src = 2'b01; end
            C_OP_STORE: begin o_mem_write = 1'b1; o_alu_src = 1'b1; o_imm_src = 3'b001; end
            C_OP_BR:    begin o_branch = 1'b1; o_imm_src = 3'b010; end
            C_OP_JAL:   begin o_reg_write = 1'b1; o_jump = 1'b1; o_result_src = 2'b10;
                              o_imm_src = 3'b100; end
            C_OP_JALR:  begin o_reg_write = 1'b1; o_jump = 1'b1; o_result_src = 2'b10;
                              o_alu_src = 1'b1; end
            C_OP_LUI:   begin o_reg_write = 1'b1; o_alu_src = 1'b1; o_imm_src = 3'b011; end
            C_OP_AUIPC: begin o_reg_write = 1'b1; o_result_src = 2'b11; o_imm_src = 3'b011; end
            default:    ;
        endcase
    end

    always_comb begin
        o_alu_control = 4'b0000;
        if (i_op == C_OP_BR) begin
            o_alu_control = 4'b0001;
        end else if (i_op == C_OP_LUI) begin
            o_alu_control = 4'b1010;
        end else if (w_arith) begin
            case (i_funct3)
                // Only the R-type form of funct3=000 can be SUB; addi has no SUB.
                3'b000:  o_alu_control = (i_op == C_OP_R && i_funct7b5) ? 4'b0001 : 4'b0000;
                3'b001:  o_alu_control = 4'b0010;
                3'b010:  o_alu_control = 4'b0011;
                3'b011:  o_alu_control = 4'b0100;
                3'b100:  o_alu_control = 4'b0101;
                3'b101:  o_alu_control = i_funct7b5 ? 4'b0111 : 4'b0110;
                3'b110:  o_alu_control = 4'b1000;
                default: o_alu_control = 4'b1001;
            endcase
        end
    end
endmodule

// ----------------------------------------------------------------------------
// sign_extend: builds the 32-bit immediate selected by i_imm_src.
// ----------------------------------------------------------------------------
module sign_extend (
    input  logic [31:7] i_ins,
    input  logic [2:0]  i_imm_src,
    output logic [31:0] o_imm_ext
);
    always_comb begin
        case (i_imm_src)
            3'b001:  o_imm_ext = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
            3'b010:  o_imm_ext = {{20{i_ins[31]}}, i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
            3'b011:  o_imm_ext = {i_ins[31:12], 12'h000};
            3'b100:  o_imm_ext = {{12{i_ins[31]}}, i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
            default: o_imm_ext = {{20{i_ins[31]}}, i_ins[31:20]};
        endcase
    end
endmodule

// ----------------------------------------------------------------------------
// decode_stage: top level
// ----------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           ins_f,
    input  logic [DATA_WIDTH-1:0] pc_f,
    input  logic [DATA_WIDTH-1:0] pc_plus_4_f,
    input  logic                  valid_f,
    input  logic                  stall_i,
    input  logic                  flush_d,
    input  logic                  reg_write_w,
    input  logic [ADDR_WIDTH-1:0] rd_w,
    input  logic [DATA_WIDTH-1:0] result_w,
    input  logic [1:0]            result_src_e,
    input  logic [ADDR_WIDTH-1:0] rd_e,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic                  valid_d,
    output logic                  reg_write_d,
    output logic [1:0]            result_src_d,
    output logic                  mem_write_d,
    output logic                  branch_d,
    output logic                  jump_d,
    output logic [3:0]            alu_control_d,
    output logic                  alu_src_d,
    output logic [2:0]            funct3_d,
    output logic [ADDR_WIDTH-1:0] rs1_d,
    output logic [ADDR_WIDTH-1:0] rs2_d,
    output logic [ADDR_WIDTH-1:0] rd_d,
    output logic [DATA_WIDTH-1:0] rd_1,
    output logic [DATA_WIDTH-1:0] rd_2,
    output logic [DATA_WIDTH-1:0] imm_ext_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus_4_d,
    output logic                  hazard_stall,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam int          C_NREGS    = 2 ** ADDR_WIDTH;
    localparam logic [6:0]  C_OP_R     = 7'b0110011;
    localparam logic [6:0]  C_OP_STORE = 7'b0100011;
    localparam logic [6:0]  C_OP_BR    = 7'b1100011;
    localparam logic [6:0]  C_OP_JAL   = 7'b1101111;
    localparam logic [6:0]  C_OP_LUI   = 7'b0110111;
    localparam logic [6:0]  C_OP_AUIPC = 7'b0010111;

    // F/D pipeline register
    logic                  r_valid;
    logic [31:0]           r_ins;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_pc4;

    logic [DATA_WIDTH-1:0] r_regs [C_NREGS];

    logic [6:0]            w_op;
    logic [ADDR_WIDTH-1:0] w_rs1;
    logic [ADDR_WIDTH-1:0] w_rs2;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic                  w_hazard;
    logic                  w_byp_rs1;
    logic                  w_byp_rs2;
    logic [DATA_WIDTH-1:0] w_rf_rs1;
    logic [DATA_WIDTH-1:0] w_rf_rs2;
    logic                  w_reg_write;
    logic                  w_mem_write;
    logic                  w_branch;
    logic                  w_jump;
    logic [2:0]            w_imm_src;
    logic [31:0]           w_imm32;

    // Flush outranks every hold source; a held slot keeps all its fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ins   <= C_NOP;
            r_pc    <= '0;
            r_pc4   <= '0;
        end else if (flush_d) begin
            r_valid <= 1'b0;
            r_ins   <= C_NOP;
        end else if (!(stall_i || w_hazard)) begin
            r_valid <= valid_f;
            r_ins   <= ins_f;
            r_pc    <= pc_f;
            r_pc4   <= pc_plus_4_f;
        end
    end

    // Register file; writes landing in a reset cycle are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (reg_write_w && (rd_w != '0)) begin
            r_regs[rd_w] <= result_w;
        end
    end

    assign w_op  = r_ins[6:0];
    assign w_rs1 = ADDR_WIDTH'(r_ins[19:15]);
    assign w_rs2 = ADDR_WIDTH'(r_ins[24:20]);

    assign w_rf_rs1 = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rf_rs2 = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            assign w_byp_rs1 = reg_write_w && (rd_w == w_rs1) && (w_rs1 != '0);
            assign w_byp_rs2 = reg_write_w && (rd_w == w_rs2) && (w_rs2 != '0);
        end else begin : g_no_bypass
            assign w_byp_rs1 = 1'b0;
            assign w_byp_rs2 = 1'b0;
        end
    endgenerate

    assign rd_1     = w_byp_rs1 ? result_w : w_rf_rs1;
    assign rd_2     = w_byp_rs2 ? result_w : w_rf_rs2;
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

    // Load-use detection: only a load in E whose rd feeds an operand this
    // instruction actually reads forces the one-cycle bubble.
    assign w_uses_rs1 = !((w_op == C_OP_LUI) || (w_op == C_OP_AUIPC) || (w_op == C_OP_JAL));
    assign w_uses_rs2 = (w_op == C_OP_R) || (w_op == C_OP_STORE) || (w_op == C_OP_BR);
    assign w_hazard   = r_valid && (result_src_e == 2'b01) && (rd_e != '0) &&
                        ((w_uses_rs1 && (w_rs1 == rd_e)) || (w_uses_rs2 && (w_rs2 == rd_e)));

    control_unit u_control_unit (
        .i_op          (w_op),
        .i_funct3      (r_ins[14:12]),
        .i_funct7b5    (r_ins[30]),
        .o_reg_write   (w_reg_write),
        .o_result_src  (result_src_d),
        .o_mem_write   (w_mem_write),
        .o_branch      (w_branch),
        .o_jump        (w_jump),
        .o_alu_control (alu_control_d),
        .o_alu_src     (alu_src_d),
        .o_imm_src     (w_imm_src)
    );

    sign_extend u_sign_extend (
        .i_ins     (r_ins[31:7]),
        .i_imm_src (w_imm_src),
        .o_imm_ext (w_imm32)
    );

    generate
        if (DATA_WIDTH > 32) begin : g_imm_wide
            assign imm_ext_d = {{(DATA_WIDTH-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign imm_ext_d = w_imm32[DATA_WIDTH-1:0];
        end
    endgenerate

    assign valid_d      = r_valid;
    assign reg_write_d  = r_valid && w_reg_write;
    assign mem_write_d  = r_valid && w_mem_write;
    assign branch_d     = r_valid && w_branch;
    assign jump_d       = r_valid && w_jump;
    assign hazard_stall = w_hazard;
    assign funct3_d     = r_ins[14:12];
    assign rs1_d        = w_rs1;
    assign rs2_d        = w_rs2;
    assign rd_d         = ADDR_WIDTH'(r_ins[11:7]);
    assign pc_d         = r_pc;
    assign pc_plus_4_d  = r_pc4;
endmodule

`default_nettype wire
